// File: rtl/frame_stat_accum_pkg.sv
// Shared types and width helpers for the frame statistics accumulator.
package frame_stat_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ACCUM = 2'b01,
      DONE  = 2'b10
   } state_t;

   function automatic int cnt_w(input int frame_len);
      return $clog2(frame_len + 1);
   endfunction

   // Enough headroom for FRAME_LEN full-scale samples without wrap.
   function automatic int sum_w(input int width, input int frame_len);
      return width + $clog2(frame_len);
   endfunction

endpackage

// File: rtl/frame_stat_accum_if.sv
// Sample stream in, held frame result out, plus FSM state for observation.
// Handshake: a transfer happens on a cycle where both valid and its ready are high.
interface frame_stat_accum_if
   import frame_stat_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 4
);
   localparam int CNT_W = cnt_w(FRAME_LEN);
   localparam int SUM_W = sum_w(WIDTH, FRAME_LEN);

   logic             start;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [SUM_W-1:0] out_sum;
   logic [WIDTH-1:0] out_max;
   logic [WIDTH-1:0] out_min;
   logic [CNT_W-1:0] out_max_idx;
   logic [CNT_W-1:0] out_min_idx;
   logic             busy;
   state_t           state;

   modport master (
      output start, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_max, out_min,
             out_max_idx, out_min_idx, busy, state
   );

   modport slave (
      input  start, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_max, out_min,
             out_max_idx, out_min_idx, busy, state
   );

endinterface

// File: rtl/frame_stat_accum_stat_update.sv
// Next max/min/index selection for one accepted sample.
// Strict compares keep the earliest index on ties.
module stat_update #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic             first,
   input  logic [WIDTH-1:0] data,
   input  logic [CNT_W-1:0] idx,
   input  logic [WIDTH-1:0] cur_max,
   input  logic [WIDTH-1:0] cur_min,
   input  logic [CNT_W-1:0] cur_max_idx,
   input  logic [CNT_W-1:0] cur_min_idx,
   output logic [WIDTH-1:0] nxt_max,
   output logic [WIDTH-1:0] nxt_min,
   output logic [CNT_W-1:0] nxt_max_idx,
   output logic [CNT_W-1:0] nxt_min_idx
);

   always_comb begin
      nxt_max     = cur_max;
      nxt_max_idx = cur_max_idx;
      nxt_min     = cur_min;
      nxt_min_idx = cur_min_idx;
      if (first || (data > cur_max)) begin
         nxt_max     = data;
         nxt_max_idx = idx;
      end
      if (first || (data < cur_min)) begin
         nxt_min     = data;
         nxt_min_idx = idx;
      end
   end

endmodule

// File: rtl/frame_stat_accum.sv
// Accumulates a frame of FRAME_LEN samples into sum, max and min (with positions)
// and holds the result until downstream takes it.
module frame_stat_accum
   import frame_stat_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 4
) (
   input logic                clk,
   input logic                rst_n,
   frame_stat_accum_if.slave  bus
);

   localparam int CNT_W = cnt_w(FRAME_LEN);
   localparam int SUM_W = sum_w(WIDTH, FRAME_LEN);

   state_t           state;
   state_t           next_state;
   logic             in_ready;
   logic             out_valid;
   logic             busy;
   logic             accept;
   logic             last;

   logic [CNT_W-1:0] cnt;
   logic [SUM_W-1:0] sum;
   logic [WIDTH-1:0] max_r;
   logic [WIDTH-1:0] min_r;
   logic [CNT_W-1:0] max_idx_r;
   logic [CNT_W-1:0] min_idx_r;

   logic [SUM_W-1:0] nxt_sum;
   logic [WIDTH-1:0] nxt_max;
   logic [WIDTH-1:0] nxt_min;
   logic [CNT_W-1:0] nxt_max_idx;
   logic [CNT_W-1:0] nxt_min_idx;

   logic [SUM_W-1:0] out_sum;
   logic [WIDTH-1:0] out_max;
   logic [WIDTH-1:0] out_min;
   logic [CNT_W-1:0] out_max_idx;
   logic [CNT_W-1:0] out_min_idx;

   assign accept  = bus.in_valid & in_ready;
   assign last    = (cnt == CNT_W'(FRAME_LEN - 1));
   assign nxt_sum = sum + SUM_W'(bus.in_data);

   stat_update #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_stat_update (
      .first       (cnt == '0),
      .data        (bus.in_data),
      .idx         (cnt),
      .cur_max     (max_r),
      .cur_min     (min_r),
      .cur_max_idx (max_idx_r),
      .cur_min_idx (min_idx_r),
      .nxt_max     (nxt_max),
      .nxt_min     (nxt_min),
      .nxt_max_idx (nxt_max_idx),
      .nxt_min_idx (nxt_min_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) next_state = ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (bus.in_valid && last) next_state = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (bus.out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Working registers restart on start; result registers load only on the
   // final sample so they keep the previous frame's result through IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         sum         <= '0;
         max_r       <= '0;
         min_r       <= '0;
         max_idx_r   <= '0;
         min_idx_r   <= '0;
         out_sum     <= '0;
         out_max     <= '0;
         out_min     <= '0;
         out_max_idx <= '0;
         out_min_idx <= '0;
      end else begin
         if ((state == IDLE) && bus.start) begin
            cnt <= '0;
            sum <= '0;
         end else if (accept) begin
            cnt       <= cnt + CNT_W'(1);
            sum       <= nxt_sum;
            max_r     <= nxt_max;
            min_r     <= nxt_min;
            max_idx_r <= nxt_max_idx;
            min_idx_r <= nxt_min_idx;
         end
         if (accept && last) begin
            out_sum     <= nxt_sum;
            out_max     <= nxt_max;
            out_min     <= nxt_min;
            out_max_idx <= nxt_max_idx;
            out_min_idx <= nxt_min_idx;
         end
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid;
   assign bus.busy        = busy;
   assign bus.state       = state;
   assign bus.out_sum     = out_sum;
   assign bus.out_max     = out_max;
   assign bus.out_min     = out_min;
   assign bus.out_max_idx = out_max_idx;
   assign bus.out_min_idx = out_min_idx;

endmodule

// File: doc/frame_stat_accum.md
Name: frame_stat_accum

Overview:
- Sequential successor to the team's combinational adder, comparator and 3-input max blocks.
- Accepts a frame of FRAME_LEN unsigned samples over a valid/ready stream, one per cycle.
- Accumulates the running sum and tracks the running max and min with position tags.
- Presents the frame statistics on a held output handshake; sits between the sample source and downstream control logic.

Parameters:
- WIDTH, 8, sample width in bits (unsigned).
- FRAME_LEN, 4, samples per frame; must be ≥2.
- CNT_W, $clog2(FRAME_LEN+1), sample-counter width (derived, not overridden).
- SUM_W, WIDTH+$clog2(FRAME_LEN), sum width; guaranteed overflow-free.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin a new frame; honoured only in IDLE.
- in_valid  in  1  sample present.
- in_data  in  WIDTH  sample value.
- in_ready  out  1  block accepts a sample this cycle.
- out_valid  out  1  frame result available.
- out_ready  in  1  downstream consumes the result.
- out_sum  out  SUM_W  sum of frame samples.
- out_max  out  WIDTH  largest sample.
- out_min  out  WIDTH  smallest sample.
- out_max_idx  out  CNT_W  index (0-based) of the first occurrence of the max.
- out_min_idx  out  CNT_W  index of the first occurrence of the min.
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; all outputs 0; in_ready=0; internal counter, sum, max and min registers 0. Assertion mid-frame aborts the frame immediately with no result emitted.
- IDLE:
  - in_ready=0, busy=0; in_valid is ignored.
  - start=1 → ACCUM next cycle; counter cleared; sum cleared.
- ACCUM:
  - in_ready=1; a sample is accepted on any cycle with in_valid & in_ready.
  - Sample k=0 loads max=min=in_data and max_idx=min_idx=0.
  - Sample k>0: sum+=in_data, zero-extended to SUM_W. Max updates only if in_data>max (strictly), so ties keep the earlier index; min likewise with in_data<min.
  - Cycles without in_valid change nothing (bubbles allowed).
  - start in ACCUM is ignored.
  - Acceptance of sample FRAME_LEN-1 → DONE next cycle.
- DONE:
  - out_valid=1 and in_ready=0.
  - out_* registered and stable until handshake.
  - out_valid & out_ready → IDLE next cycle; out_valid drops the cycle after the handshake.
  - start during DONE is ignored, including the handshake cycle; a new frame needs start in IDLE.
- Latency: out_valid rises exactly 1 cycle after the last sample is accepted. Minimum frame time is FRAME_LEN+2 cycles (start, samples, result).
- Output registers hold their last values in IDLE until the next result overwrites them.
- Arithmetic: all operands unsigned. The all-ones frame gives sum=FRAME_LEN*(2^WIDTH-1), with no wrap.

Decomposition:
- Shared package frame_stat_pkg:
  - state encoding typedef {IDLE=2'b00, ACCUM=2'b01, DONE=2'b10}
  - width helper functions for CNT_W/SUM_W
- One natural sub-module: stat_update, a combinational next max/min/idx selector (extends the 3-input max logic with min and strict-compare tie rule). Instantiated once; the FSM and accumulator stay in the top.

Test Plan:
- WIDTH=8, FRAME_LEN=4; start then 3,9,1,7 back-to-back → out_valid 1 cycle after 4th sample; sum=20, max=9 idx1, min=1 idx2.
- Ties: 5,5,5,5 → sum=20, max=min=5, both idx=0.
- Bubbles: samples 200,0,255,10 with in_valid low 2 cycles between each → sum=465 (SUM_W=10), max=255 idx2, min=0 idx1.
- Backpressure: hold out_ready=0 for 5 cycles with start and in_valid toggling → outputs stable, in_ready=0, no state change; out_ready=1 → IDLE next cycle.
- rst_n low asynchronously after the 2nd sample → all outputs 0 immediately. New frame 1,2,3,4 → sum=10, no residue from the aborted frame.
- All-ones with WIDTH=8, FRAME_LEN=4 → sum=1020 with no overflow. In_valid in IDLE without start → in_ready=0, no result produced.
